// File: rtl/uart_tx_if.sv
// Byte handshake between a producer and the UART transmitter.
// master = byte producer, slave = uart_tx.
interface uart_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: one byte per handshake, start/8 data LSB first/stop.
// Define UART_TX_PARITY_EN to add an even parity bit after the data bits.
module uart_tx #(
    parameter int BAUD_RATE  = 9600,
    parameter int CLOCK_FREQ = 50000000
) (
    input  logic       clk,
    input  logic       rst_n,
    uart_tx_if.slave   s,
    output logic       data_out,
    output logic       busy,
    output logic       done
);
    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam logic [31:0] BIT_LAST = 32'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        line_q, line_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        ready_q, ready_d;
    logic        bit_end;

    assign bit_end    = (cnt_q == BIT_LAST);
    assign s.tx_ready = ready_q;
    assign data_out   = line_q;
    assign busy       = busy_q;
    assign done       = done_q;

    // State, timers and registered outputs; reset aborts any frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            line_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            line_q  <= line_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    // Next state plus next-cycle output values derived from it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 32'd1;
        idx_d   = idx_q;
        shift_d = shift_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (s.tx_valid && ready_q) begin
                    state_d = START;
                    shift_d = s.tx_data;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    cnt_d   = '0;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        line_d  = 1'b1;
        busy_d  = (state_d != IDLE);
        ready_d = (state_d == IDLE);
        unique case (state_d)
            START:   line_d = 1'b0;
            DATA:    line_d = shift_d[idx_d];
`ifdef UART_TX_PARITY_EN
            PARITY:  line_d = ^shift_d;
`endif
            default: line_d = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx at 8 clocks per bit.
// Frame expectations come from a bit-list model of the serial format.
module tb_uart_tx;
    localparam int BAUD = 1000000;
    localparam int FCLK = 8000000;
    localparam int CPB  = FCLK / BAUD;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    typedef struct {
        logic [7:0] data;
        logic       par;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic data_out;
    logic busy;
    logic done;
    int   tests = 0;
    int   fails = 0;

    uart_tx_if bus ();

    uart_tx #(
        .BAUD_RATE  (BAUD),
        .CLOCK_FREQ (FCLK)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s        (bus),
        .data_out (data_out),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t",
                         name, act, exp, $time);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " line"},  data_out,     1);
        chk({tag, " ready"}, bus.tx_ready, 1);
        chk({tag, " busy"},  busy,         0);
        chk({tag, " done"},  done,         0);
    endtask

    // Waits (bounded) for ready, then presents a byte for one edge.
    task automatic send(input logic [7:0] d, input bit keep);
        int n = 0;
        while (bus.tx_ready !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("ready wait", bus.tx_ready, 1);
        bus.tx_valid = 1'b1;
        bus.tx_data  = d;
        @(negedge clk);
        if (!keep) bus.tx_valid = 1'b0;
    endtask

    // Called in the first start-bit cycle; returns in the done cycle.
    task automatic frame(input logic [7:0] d, input logic par);
        logic bits[$];
        bits = {};
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (PAR) bits.push_back(par);
        bits.push_back(1'b1);
        for (int b = 0; b < bits.size(); b++) begin
            for (int c = 0; c < CPB; c++) begin
                chk($sformatf("line %02h bit%0d", d, b), data_out, bits[b]);
                chk("busy in frame",  busy,         1);
                chk("ready in frame", bus.tx_ready, 0);
                chk("done in frame",  done,         0);
                @(negedge clk);
            end
        end
        chk("done pulse",   done,         1);
        chk("ready at end", bus.tx_ready, 1);
        chk("busy at end",  busy,         0);
        chk("line at end",  data_out,     1);
    endtask

    initial begin
        vec_t vecs[6];
        logic [7:0] d;
        int gap;

        vecs[0] = '{8'hA5, 1'b0};
        vecs[1] = '{8'h07, 1'b1};
        vecs[2] = '{8'h03, 1'b0};
        vecs[3] = '{8'h3C, 1'b0};
        vecs[4] = '{8'h80, 1'b1};
        vecs[5] = '{8'h01, 1'b1};

        rst_n        = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 200; i++) begin
            chk_idle("reset idle");
            @(negedge clk);
        end

        foreach (vecs[i]) begin
            send(vecs[i].data, 1'b0);
            frame(vecs[i].data, vecs[i].par);
            @(negedge clk);
            chk("done one cycle", done, 0);
        end

        // Held valid: second byte written while busy, accepted at done.
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'h00;
        @(negedge clk);
        bus.tx_data = 8'hFF;
        frame(8'h00, 1'b0);
        @(negedge clk);
        bus.tx_valid = 1'b0;
        frame(8'hFF, 1'b0);
        @(negedge clk);
        chk_idle("after b2b");

        // Reset during data bit 3 aborts cleanly.
        send(8'h5A, 1'b0);
        repeat (CPB + 3 * CPB + 2) @(negedge clk);
        chk("mid bit3 busy", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk_idle("abort");
        for (int i = 0; i < 3 * CPB; i++) begin
            chk("abort no done", done, 0);
            chk("abort line", data_out, 1);
            @(negedge clk);
        end
        send(8'hC3, 1'b0);
        frame(8'hC3, 1'b0);
        @(negedge clk);

        // Random bytes and gaps, including back-to-back.
        for (int i = 0; i < 24; i++) begin
            d = 8'($urandom);
            send(d, 1'b0);
            frame(d, ^d);
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                chk_idle("gap");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
